// File: rtl/can_pkg.sv
// Shared types and constants for the CAN error-frame generator.
package can_pkg;

   // Error-frame sequencer states.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FLAG  = 3'd1,
      WAIT  = 3'd2,
      DELIM = 3'd3,
      INTER = 3'd4
   } state_t;

   // Error cause codes; a lower value wins when several strobes are low together.
   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_STUFF = 3'd1;
   localparam logic [2:0] ERR_CRC   = 3'd2;
   localparam logic [2:0] ERR_FORM  = 3'd3;
   localparam logic [2:0] ERR_ACK   = 3'd4;
   localparam logic [2:0] ERR_EOF   = 3'd5;

   // Bus levels.
   localparam logic DOMINANT  = 1'b0;
   localparam logic RECESSIVE = 1'b1;

   // Saturating increment for the 8-bit error-frame counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/can_err_prio_enc.sv
// Priority encoder from the five active-low checker strobes to a cause code.
module can_err_prio_enc
   import can_pkg::*;
(
   input  logic       stuff_error_n,
   input  logic       crc_error_n,
   input  logic       form_error_n,
   input  logic       ack_error_n,
   input  logic       eof_error_n,
   output logic       any,
   output logic [2:0] code
);

   // Lowest-numbered active strobe selects the code.
   always_comb begin
      any  = 1'b1;
      code = ERR_NONE;
      if (!stuff_error_n) begin
         code = ERR_STUFF;
      end else if (!crc_error_n) begin
         code = ERR_CRC;
      end else if (!form_error_n) begin
         code = ERR_FORM;
      end else if (!ack_error_n) begin
         code = ERR_ACK;
      end else if (!eof_error_n) begin
         code = ERR_EOF;
      end else begin
         any = 1'b0;
      end
   end

endmodule

// File: rtl/can_error_frame_gen.sv
// CAN active error-frame generator: flag, delimiter and intermission on tx,
// plus latched cause code, saturating frame counter and sticky bus-stuck flag.
module can_error_frame_gen
   import can_pkg::*;
#(
   parameter int unsigned FLAG_LEN  = 6,
   parameter int unsigned DELIM_LEN = 8,
   parameter int unsigned INTER_LEN = 3,
   parameter int unsigned MAX_WAIT  = 15
) (
   input  logic       sp,
   input  logic       reset,
   input  logic       rx,
   input  logic       eof_error_n,
   input  logic       stuff_error_n,
   input  logic       crc_error_n,
   input  logic       form_error_n,
   input  logic       ack_error_n,
   output logic       tx,
   output logic       error_active,
   output logic [2:0] err_code,
   output logic [7:0] err_count,
   output logic       bus_stuck
);

   // Terminal counter values; the WAIT state entry edge already accounts for
   // the first delimiter bit, so DELIM stops one short of DELIM_LEN.
   localparam logic [3:0] FLAG_LAST  = 4'(FLAG_LEN);
   localparam logic [3:0] DELIM_LAST = 4'(DELIM_LEN - 1);
   localparam logic [3:0] INTER_LAST = 4'(INTER_LEN);
   localparam logic [3:0] WAIT_LAST  = 4'(MAX_WAIT - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] bitcnt;
   logic [3:0] bitcnt_next;
   logic [3:0] waitcnt;
   logic [3:0] waitcnt_next;
   logic [2:0] code_next;
   logic [7:0] count_next;
   logic       stuck_next;
   logic       tx_next;
   logic       active_next;

   logic       err_any;
   logic [2:0] err_sel;

   can_err_prio_enc u_prio (
      .stuff_error_n (stuff_error_n),
      .crc_error_n   (crc_error_n),
      .form_error_n  (form_error_n),
      .ack_error_n   (ack_error_n),
      .eof_error_n   (eof_error_n),
      .any           (err_any),
      .code          (err_sel)
   );

   // Next-state, counter and output decode for the error-frame sequencer.
   always_comb begin
      state_next   = state;
      bitcnt_next  = bitcnt;
      waitcnt_next = waitcnt;
      code_next    = err_code;
      count_next   = err_count;
      stuck_next   = bus_stuck;

      unique case (state)
         IDLE: begin
            if (err_any) begin
               code_next   = err_sel;
               count_next  = sat_inc8(err_count);
               bitcnt_next = 4'd1;
               state_next  = FLAG;
            end
         end

         FLAG: begin
            if (bitcnt == FLAG_LAST) begin
               waitcnt_next = '0;
               state_next   = WAIT;
            end else begin
               bitcnt_next = bitcnt + 4'd1;
            end
         end

         WAIT: begin
            if (rx == RECESSIVE) begin
               bitcnt_next = 4'd1;
               state_next  = DELIM;
            end else begin
               waitcnt_next = waitcnt + 4'd1;
               if (waitcnt == WAIT_LAST) begin
                  stuck_next = 1'b1;
                  state_next = IDLE;
               end
            end
         end

         DELIM: begin
            if (rx == DOMINANT) begin
               code_next   = ERR_FORM;
               count_next  = sat_inc8(err_count);
               bitcnt_next = 4'd1;
               state_next  = FLAG;
            end else if (bitcnt == DELIM_LAST) begin
               bitcnt_next = 4'd1;
               state_next  = INTER;
            end else begin
               bitcnt_next = bitcnt + 4'd1;
            end
         end

         INTER: begin
            if (err_any) begin
               code_next   = err_sel;
               count_next  = sat_inc8(err_count);
               bitcnt_next = 4'd1;
               state_next  = FLAG;
            end else if (bitcnt == INTER_LAST) begin
               state_next = IDLE;
            end else begin
               bitcnt_next = bitcnt + 4'd1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // tx and error_active are registered from the next state so they
      // change in the same bit time as the edge that caused the transition.
      tx_next     = (state_next == FLAG) ? DOMINANT : RECESSIVE;
      active_next = (state_next == FLAG) || (state_next == WAIT) ||
                    (state_next == DELIM);
   end

   // State, counters and registered outputs; reset aborts any frame at once.
   always_ff @(posedge sp or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         bitcnt       <= '0;
         waitcnt      <= '0;
         tx           <= RECESSIVE;
         error_active <= 1'b0;
         err_code     <= ERR_NONE;
         err_count    <= '0;
         bus_stuck    <= 1'b0;
      end else begin
         state        <= state_next;
         bitcnt       <= bitcnt_next;
         waitcnt      <= waitcnt_next;
         tx           <= tx_next;
         error_active <= active_next;
         err_code     <= code_next;
         err_count    <= count_next;
         bus_stuck    <= stuck_next;
      end
   end

endmodule

// File: tb/tb_can_error_frame_gen.sv
// Scoreboard bench for can_error_frame_gen: stimulus pushes per-edge
// expectations, a monitor pops and compares one entry after each sp edge.
module tb_can_error_frame_gen;

   localparam logic [1:0] M_FULL = 2'd0;
   localparam logic [1:0] M_CNT  = 2'd1;
   localparam logic [1:0] M_SKIP = 2'd2;

   // err_n bit order: [0]=stuff [1]=crc [2]=form [3]=ack [4]=eof
   localparam logic [4:0] NONE    = 5'b11111;
   localparam logic [4:0] E_STUFF = 5'b11110;
   localparam logic [4:0] E_ACK   = 5'b10111;
   localparam logic [4:0] E_EOF   = 5'b01111;
   localparam logic [4:0] E_CRCACK = 5'b10101;
   localparam logic [4:0] E_CRC   = 5'b11101;

   typedef struct packed {
      logic [1:0] mode;
      logic       tx;
      logic       act;
      logic [2:0] code;
      logic [7:0] cnt;
      logic       stuck;
   } exp_t;

   logic       sp;
   logic       reset;
   logic       rx;
   logic [4:0] err_n;
   logic       tx;
   logic       error_active;
   logic [2:0] err_code;
   logic [7:0] err_count;
   logic       bus_stuck;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    passes = 0;

   can_error_frame_gen #(
      .FLAG_LEN  (6),
      .DELIM_LEN (8),
      .INTER_LEN (3),
      .MAX_WAIT  (15)
   ) dut (
      .sp            (sp),
      .reset         (reset),
      .rx            (rx),
      .eof_error_n   (err_n[4]),
      .stuff_error_n (err_n[0]),
      .crc_error_n   (err_n[1]),
      .form_error_n  (err_n[2]),
      .ack_error_n   (err_n[3]),
      .tx            (tx),
      .error_active  (error_active),
      .err_code      (err_code),
      .err_count     (err_count),
      .bus_stuck     (bus_stuck)
   );

   initial begin
      sp = 1'b0;
      forever #5 sp = ~sp;
   end

   function automatic exp_t mk(input logic [1:0] m, input logic t, input logic a,
                               input logic [2:0] c, input logic [7:0] n, input logic s);
      exp_t e;
      e.mode = m; e.tx = t; e.act = a; e.code = c; e.cnt = n; e.stuck = s;
      return e;
   endfunction

   task automatic compare(input exp_t e, input string nm);
      logic ok;
      if (e.mode == M_CNT) ok = (err_count == e.cnt);
      else ok = (tx == e.tx) && (error_active == e.act) && (err_code == e.code) &&
                (err_count == e.cnt) && (bus_stuck == e.stuck);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s @%0t: got tx=%b act=%b code=%0d cnt=%0d stuck=%b, want tx=%b act=%b code=%0d cnt=%0d stuck=%b (mode %0d)",
                    nm, $time, tx, error_active, err_code, err_count, bus_stuck,
                    e.tx, e.act, e.code, e.cnt, e.stuck, e.mode);
   endtask

   // Monitor: one expectation per sp edge, sampled 1 time unit after it.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(posedge sp);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.mode != M_SKIP) compare(e, nm);
         end
      end
   end

   task automatic step(input logic r, input logic [4:0] e, input logic t, input logic a,
                       input logic [2:0] c, input logic [7:0] n, input logic s, input string nm);
      @(negedge sp);
      rx = r; err_n = e;
      exp_q.push_back(mk(M_FULL, t, a, c, n, s));
      name_q.push_back(nm);
   endtask

   task automatic skip(input logic r, input logic [4:0] e);
      @(negedge sp);
      rx = r; err_n = e;
      exp_q.push_back(mk(M_SKIP, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0));
      name_q.push_back("skip");
   endtask

   task automatic step_cnt(input logic [7:0] n, input string nm);
      @(negedge sp);
      exp_q.push_back(mk(M_CNT, 1'b1, 1'b0, 3'd0, n, 1'b0));
      name_q.push_back(nm);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge sp);
      #2;
      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("FAIL drain: got %0d pending, want 0", exp_q.size());
   endtask

   // Async reset between edges, checked immediately without a clock edge.
   task automatic do_reset(input string nm);
      reset = 1'b1;
      #1;
      compare(mk(M_FULL, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0), nm);
      @(negedge sp);
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; rx = 1'b1; err_n = NONE;
      #3;
      compare(mk(M_FULL, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0), "por");
      @(negedge sp);
      reset = 1'b0;

      // EOF error: 6 dominant, 8 recessive active, 3 intermission, idle.
      step(1, E_EOF, 0, 1, 5, 1, 0, "eof_start");
      repeat (5) step(1, NONE, 0, 1, 5, 1, 0, "eof_flag");
      repeat (8) step(1, NONE, 1, 1, 5, 1, 0, "eof_delim");
      repeat (3) step(1, NONE, 1, 0, 5, 1, 0, "eof_inter");
      repeat (2) step(1, NONE, 1, 0, 5, 1, 0, "eof_idle");
      drain();

      // Reset at the third dominant bit.
      step(1, E_STUFF, 0, 1, 1, 2, 0, "mid_start");
      repeat (2) step(1, NONE, 0, 1, 1, 2, 0, "mid_flag");
      drain();
      do_reset("mid_reset");

      // CRC and ACK together: CRC wins; held low into FLAG it is ignored.
      step(1, E_CRCACK, 0, 1, 2, 1, 0, "dual_start");
      step(1, E_CRCACK, 0, 1, 2, 1, 0, "dual_ignored");
      repeat (4) step(1, NONE, 0, 1, 2, 1, 0, "dual_flag");
      repeat (8) step(1, NONE, 1, 1, 2, 1, 0, "dual_delim");
      repeat (3) step(1, NONE, 1, 0, 2, 1, 0, "dual_inter");
      step(1, NONE, 1, 0, 2, 1, 0, "dual_idle");

      // Flag extended by other nodes: 4 dominant bits in WAIT.
      step(1, E_STUFF, 0, 1, 1, 2, 0, "ext_start");
      repeat (5) step(1, NONE, 0, 1, 1, 2, 0, "ext_flag");
      step(0, NONE, 1, 1, 1, 2, 0, "ext_enter_wait");
      repeat (4) step(0, NONE, 1, 1, 1, 2, 0, "ext_wait");
      repeat (7) step(1, NONE, 1, 1, 1, 2, 0, "ext_delim");
      repeat (3) step(1, NONE, 1, 0, 1, 2, 0, "ext_inter");
      step(1, NONE, 1, 0, 1, 2, 0, "ext_idle");
      drain();
      do_reset("reset_2");

      // Dominant at the 5th delimiter bit restarts as a form error.
      step(1, E_ACK, 0, 1, 4, 1, 0, "form_start");
      repeat (5) step(1, NONE, 0, 1, 4, 1, 0, "form_flag1");
      step(1, NONE, 1, 1, 4, 1, 0, "form_wait");
      repeat (4) step(1, NONE, 1, 1, 4, 1, 0, "form_delim1");
      step(0, NONE, 0, 1, 3, 2, 0, "form_err");
      repeat (5) step(1, NONE, 0, 1, 3, 2, 0, "form_flag2");
      repeat (8) step(1, NONE, 1, 1, 3, 2, 0, "form_delim2");
      repeat (3) step(1, NONE, 1, 0, 3, 2, 0, "form_inter");

      // Bus stuck dominant after the flag: 15 WAIT edges then sticky flag.
      step(0, E_EOF, 0, 1, 5, 3, 0, "stuck_start");
      repeat (5) step(0, NONE, 0, 1, 5, 3, 0, "stuck_flag");
      step(0, NONE, 1, 1, 5, 3, 0, "stuck_enter_wait");
      repeat (14) step(0, NONE, 1, 1, 5, 3, 0, "stuck_wait");
      step(0, NONE, 1, 0, 5, 3, 1, "stuck_set");
      repeat (3) step(0, NONE, 1, 0, 5, 3, 1, "stuck_hold");
      step(1, E_CRC, 0, 1, 2, 4, 1, "stuck_frame");
      repeat (5) step(1, NONE, 0, 1, 2, 4, 1, "stuck_frame_flag");
      repeat (8) step(1, NONE, 1, 1, 2, 4, 1, "stuck_frame_delim");
      repeat (3) step(1, NONE, 1, 0, 2, 4, 1, "stuck_frame_inter");
      drain();
      do_reset("stuck_cleared");

      // Back-to-back EOF frames well past 256: counter must hold at 255.
      repeat (4000) skip(1, E_EOF);
      step_cnt(8'd255, "sat_running");
      repeat (20) skip(1, NONE);
      step(1, NONE, 1, 0, 5, 255, 0, "sat_idle");
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
